// File: rtl/mem_read_arbiter.sv
// Shares one MMU read port between fetch and load, with an in-order tag FIFO.
// Define MEM_ARB_RR_EN for round-robin grant; default is fixed DATA-over-INST.
module mem_read_arbiter #(
    parameter int DEPTH = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        FLUSH,
    input  logic        INST_RDEN,
    input  logic [31:0] INST_RIADDR,
    output logic        INST_WAIT,
    output logic        INST_RVALID,
    output logic [31:0] INST_ROADDR,
    output logic [31:0] INST_RDATA,
    input  logic        DATA_RDEN,
    input  logic [31:0] DATA_RIADDR,
    output logic        DATA_WAIT,
    output logic        DATA_RVALID,
    output logic [31:0] DATA_ROADDR,
    output logic [31:0] DATA_RDATA,
    output logic        MEM_RDEN,
    output logic [31:0] MEM_RIADDR,
    input  logic        MEM_READY,
    input  logic        MEM_RVALID,
    input  logic [31:0] MEM_ROADDR,
    input  logic [31:0] MEM_RDATA,
    output logic        ERR_UNEXP
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [DEPTH-1:0] tag_id;
    logic [DEPTH-1:0] tag_kill;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;

    logic inst_el;
    logic data_el;
    logic pick_data;
    logic grant_inst;
    logic grant_data;
    logic full;
    logic accept;
    logic pop;
    logic head_id;
    logic head_kill;

    assign inst_el = INST_RDEN & ~FLUSH;
    assign data_el = DATA_RDEN;
    assign full    = (count == CW'(DEPTH));

`ifdef MEM_ARB_RR_EN
    logic last_data;

    assign pick_data = data_el & (~inst_el | ~last_data);

    always_ff @(posedge CLK) begin
        if (RST)
            last_data <= 1'b0;
        else if (accept)
            last_data <= grant_data;
    end
`else
    assign pick_data = data_el;
`endif

    assign grant_data = pick_data;
    assign grant_inst = inst_el & ~pick_data;

    assign MEM_RDEN   = ~RST & ~full & (inst_el | data_el);
    assign MEM_RIADDR = ~MEM_RDEN  ? 32'h0 :
                        grant_data ? DATA_RIADDR : INST_RIADDR;
    assign accept     = MEM_RDEN & MEM_READY;

    // a flushed fetch is dropped outright, so it never reports a stall
    assign INST_WAIT = ~RST & INST_RDEN & ~FLUSH & ~(grant_inst & accept);
    assign DATA_WAIT = ~RST & DATA_RDEN & ~(grant_data & accept);

    assign head_id   = tag_id[rd_ptr];
    assign head_kill = tag_kill[rd_ptr];
    assign pop       = ~RST & MEM_RVALID & (count != '0);

    assign INST_RVALID = pop & ~head_id & ~head_kill & ~FLUSH;
    assign DATA_RVALID = pop & head_id;

    assign INST_ROADDR = INST_RVALID ? MEM_ROADDR : 32'h0;
    assign INST_RDATA  = INST_RVALID ? MEM_RDATA  : NOP;
    assign DATA_ROADDR = DATA_RVALID ? MEM_ROADDR : 32'h0;
    assign DATA_RDATA  = DATA_RVALID ? MEM_RDATA  : NOP;

    always_ff @(posedge CLK) begin
        if (RST) begin
            tag_id    <= '0;
            tag_kill  <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            ERR_UNEXP <= 1'b0;
        end else begin
            // kill every INST slot; stale slots are rewritten on push anyway
            if (FLUSH)
                tag_kill <= tag_kill | ~tag_id;
            if (accept) begin
                tag_id[wr_ptr]   <= grant_data;
                tag_kill[wr_ptr] <= 1'b0;
                wr_ptr           <= wr_ptr + PW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (accept && !pop)
                count <= count + CW'(1);
            else if (pop && !accept)
                count <= count - CW'(1);
            if (MEM_RVALID && count == '0)
                ERR_UNEXP <= 1'b1;
        end
    end

endmodule
